// File: rtl/mem_arbiter.sv
// Shares the single-port 16-bit RAM between the CPU and the debug/loader port.
// Each access is a fixed IDLE -> ACCESS -> RESP sequence; the wait counter stops debug starvation.
module mem_arbiter #(
    parameter int AW           = 15,
    parameter int DBG_MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_byte,
    input  logic [AW:0]   cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [15:0]   cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_byte,
    input  logic [AW:0]   dbg_addr,
    input  logic [15:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [15:0]   dbg_rdata,
    output logic          mem_en,
    output logic [1:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata
);

    localparam int WW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(DBG_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          owner, owner_nxt;          // 1 = debug owns the current transaction
    logic          lat_we, lat_we_nxt;
    logic          lat_byte, lat_byte_nxt;
    logic [AW:0]   lat_addr, lat_addr_nxt;
    logic [15:0]   lat_wdata, lat_wdata_nxt;
    logic [WW-1:0] waitcnt, waitcnt_nxt;
    logic          dbg_win;
    logic [15:0]   rd_word;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            waitcnt   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            lat_we    <= lat_we_nxt;
            lat_byte  <= lat_byte_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            waitcnt   <= waitcnt_nxt;
        end
    end

    // Counter never exceeds WMAX, so equality is the saturation test (and is true for WMAX=0).
    assign dbg_win = dbg_req & (~cpu_req | (waitcnt == WMAX));

    always_comb begin
        if (!lat_byte)
            rd_word = mem_rdata;
        else if (lat_addr[0])
            rd_word = {8'h00, mem_rdata[15:8]};
        else
            rd_word = {8'h00, mem_rdata[7:0]};
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        lat_we_nxt    = lat_we;
        lat_byte_nxt  = lat_byte;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        mem_en        = 1'b0;
        mem_we        = 2'b00;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_ack       = 1'b0;
        cpu_rdata     = '0;
        dbg_ack       = 1'b0;
        dbg_rdata     = '0;

        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = dbg_win;
                    lat_we_nxt    = dbg_win ? dbg_we    : cpu_we;
                    lat_byte_nxt  = dbg_win ? dbg_byte  : cpu_byte;
                    lat_addr_nxt  = dbg_win ? dbg_addr  : cpu_addr;
                    lat_wdata_nxt = dbg_win ? dbg_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                mem_en   = 1'b1;
                mem_addr = lat_addr[AW:1];
                if (lat_we) begin
                    if (lat_byte) begin
                        mem_wdata = {lat_wdata[7:0], lat_wdata[7:0]};
                        mem_we    = lat_addr[0] ? 2'b10 : 2'b01;
                    end else begin
                        mem_wdata = lat_wdata;
                        mem_we    = 2'b11;
                    end
                end
                state_nxt = RESP;
            end
            RESP: begin
                if (owner) begin
                    dbg_ack   = 1'b1;
                    dbg_rdata = lat_we ? 16'h0000 : rd_word;
                end else begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = lat_we ? 16'h0000 : rd_word;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        waitcnt_nxt = waitcnt;
        if (!dbg_req || (state == RESP && owner))
            waitcnt_nxt = '0;
        else if (waitcnt != WMAX)
            waitcnt_nxt = waitcnt + 1'b1;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with the default wait limit and RAM model,
// one with DBG_MAX_WAIT=0 for the debug-first arbitration case.
module tb_mem_arbiter;

    localparam int AW = 15;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic          cpu_req = 0, cpu_we = 0, cpu_byte = 0;
    logic [AW:0]   cpu_addr = '0;
    logic [15:0]   cpu_wdata = '0;
    logic          cpu_ack;
    logic [15:0]   cpu_rdata;
    logic          dbg_req = 0, dbg_we = 0, dbg_byte = 0;
    logic [AW:0]   dbg_addr = '0;
    logic [15:0]   dbg_wdata = '0;
    logic          dbg_ack;
    logic [15:0]   dbg_rdata;
    logic          mem_en;
    logic [1:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = '0;

    logic          b_cpu_req = 0, b_dbg_req = 0;
    logic          b_cpu_ack, b_dbg_ack, b_mem_en;
    logic [15:0]   b_cpu_rdata, b_dbg_rdata, b_mem_wdata;
    logic [1:0]    b_mem_we;
    logic [AW-1:0] b_mem_addr;

    logic [15:0] ram [0:255];

    mem_arbiter #(.AW(AW), .DBG_MAX_WAIT(8)) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_byte(dbg_byte), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(AW), .DBG_MAX_WAIT(0)) dut_b (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_byte(1'b0), .cpu_addr(16'h0020),
        .cpu_wdata(16'h0000), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_byte(1'b0), .dbg_addr(16'h0022),
        .dbg_wdata(16'h0000), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(16'h5A5A)
    );

    // Synchronous RAM: byte-lane writes, read data one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we[0]) ram[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
            if (mem_we[1]) ram[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_code;
    logic       ca, da;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
        #1;
        ram[2] <= 16'h4315;
        ram[3] <= 16'h5566;
        ram[4] <= 16'h1111;

        repeat (3) step();
        arst_n = 1'b1;
        step();
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_cpu_ack", cpu_ack, 1'b0);

        // 1: reset mid-ACCESS of a word write drops it
        cpu_req = 1; cpu_we = 1; cpu_byte = 0; cpu_addr = 16'h0008; cpu_wdata = 16'hBEEF;
        step();
        check("t1_access_en", mem_en, 1'b1);
        check("t1_access_we", mem_we, 2'b11);
        arst_n = 1'b0;
        #1;
        check("t1_rst_mem_en", mem_en, 1'b0);
        check("t1_rst_mem_we", mem_we, 2'b00);
        cpu_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t1_no_ack", cpu_ack, 1'b0);
        end
        step();
        arst_n = 1'b1;
        @(negedge clk);
        check("t1_post_en", mem_en, 1'b0);
        check("t1_post_addr", mem_addr, 15'h0);
        check("t1_post_wdata", mem_wdata, 16'h0);
        check("t1_post_acks", {cpu_ack, dbg_ack}, 2'b00);
        check("t1_ram_kept", ram[4], 16'h1111);
        step();

        // 2: CPU word read of byte address 0x0004
        cpu_req = 1; cpu_we = 0; cpu_byte = 0; cpu_addr = 16'h0004;
        @(negedge clk);
        check("t2_c0_en", mem_en, 1'b0);
        step();
        @(negedge clk);
        check("t2_c1_en", mem_en, 1'b1);
        check("t2_c1_addr", mem_addr, 15'd2);
        check("t2_c1_we", mem_we, 2'b00);
        step();
        @(negedge clk);
        check("t2_c2_ack", cpu_ack, 1'b1);
        check("t2_c2_rdata", cpu_rdata, 16'h4315);
        check("t2_c2_dbg_ack", dbg_ack, 1'b0);
        step();
        cpu_req = 0;
        @(negedge clk);
        check("t2_c3_ack", cpu_ack, 1'b0);
        check("t2_c3_rdata", cpu_rdata, 16'h0);
        step();

        // 3: CPU byte write to odd address 0x0007
        cpu_req = 1; cpu_we = 1; cpu_byte = 1; cpu_addr = 16'h0007; cpu_wdata = 16'h12AB;
        step();
        @(negedge clk);
        check("t3_c1_addr", mem_addr, 15'd3);
        check("t3_c1_we", mem_we, 2'b10);
        check("t3_c1_wdata", mem_wdata, 16'hABAB);
        step();
        @(negedge clk);
        check("t3_c2_ack", cpu_ack, 1'b1);
        check("t3_ram", ram[3], 16'hAB66);
        step();
        cpu_req = 0; cpu_we = 0; cpu_byte = 0;
        ram[2] <= 16'h4378;
        step();

        // 4: debug byte read of the high lane at 0x0005
        dbg_req = 1; dbg_we = 0; dbg_byte = 1; dbg_addr = 16'h0005;
        step();
        @(negedge clk);
        check("t4_c1_addr", mem_addr, 15'd2);
        step();
        @(negedge clk);
        check("t4_c2_dbg_ack", dbg_ack, 1'b1);
        check("t4_c2_dbg_rdata", dbg_rdata, 16'h0043);
        check("t4_c2_cpu_ack", cpu_ack, 1'b0);
        check("t4_c2_cpu_rdata", cpu_rdata, 16'h0);
        step();
        dbg_req = 0; dbg_byte = 0;
        step();

        // 5: both held; CPU acks at cycles 2,5,8, debug at 11 once the counter reaches 8, CPU at 14
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0004;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0006;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 2 || i == 5 || i == 8 || i == 14) exp_code = 2'b01;
            else if (i == 11)                          exp_code = 2'b10;
            else                                       exp_code = 2'b00;
            check($sformatf("t5_acks_c%0d", i), {dbg_ack, cpu_ack}, exp_code);
            step();
        end
        cpu_req = 0; dbg_req = 0;
        step();

        // 6: DBG_MAX_WAIT=0, each side drops req for the cycle after its ack
        b_cpu_req = 1; b_dbg_req = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2 || i == 8)       exp_code = 2'b10;
            else if (i == 5 || i == 11) exp_code = 2'b01;
            else                        exp_code = 2'b00;
            check($sformatf("t6_acks_c%0d", i), {b_dbg_ack, b_cpu_ack}, exp_code);
            ca = b_cpu_ack;
            da = b_dbg_ack;
            step();
            b_cpu_req = !ca;
            b_dbg_req = !da;
        end
        b_cpu_req = 0; b_dbg_req = 0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
